// File: rtl/bp_tournament_ctrl.sv
// Tournament branch-predictor controller: chooses local/global prediction at fetch,
// tracks in-flight branches in a FIFO and issues one registered predictor update per resolution.
module bp_tournament_ctrl #(
   parameter int unsigned INDEX = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fetch_valid,
   input  logic             fetch_is_br,
   input  logic [INDEX-1:0] fetch_idx,
   input  logic             local_take,
   input  logic             global_take,
   output logic             pred_take,
   output logic             stall_fetch,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic             flush,
   output logic             upd_en,
   output logic             upd_result,
   output logic [INDEX-1:0] upd_idx,
   output logic             underflow,
   output logic [31:0]      stat_total,
   output logic [31:0]      stat_wrong
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NumEnt = 2 ** INDEX;
   localparam logic [PW:0] CntFull = (PW + 1)'(DEPTH);

   logic [INDEX-1:0] r_idx_mem [DEPTH];
   logic [DEPTH-1:0] r_loc_mem;
   logic [DEPTH-1:0] r_glb_mem;
   logic [DEPTH-1:0] r_fin_mem;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [PW:0]      r_count;
   logic [1:0]       r_chooser [NumEnt];
   logic             r_upd_en;
   logic             r_upd_result;
   logic [INDEX-1:0] r_upd_idx;
   logic             r_underflow;
   logic [31:0]      r_total;
   logic [31:0]      r_wrong;

   logic             w_sel;
   logic             w_pred;
   logic             w_push;
   logic             w_pop;
   logic [INDEX-1:0] w_hd_idx;
   logic             w_hd_loc;
   logic             w_hd_glb;
   logic             w_hd_fin;

   always_comb begin
      w_sel    = r_chooser[fetch_idx][1];
      w_pred   = w_sel ? global_take : local_take;
      w_push   = fetch_valid & fetch_is_br & (r_count != CntFull) & ~flush;
      w_pop    = res_valid & (r_count != '0);
      w_hd_idx = r_idx_mem[r_head];
      w_hd_loc = r_loc_mem[r_head];
      w_hd_glb = r_glb_mem[r_head];
      w_hd_fin = r_fin_mem[r_head];
   end

   assign pred_take   = w_pred;
   assign stall_fetch = (r_count == CntFull);
   assign upd_en      = r_upd_en;
   assign upd_result  = r_upd_result;
   assign upd_idx     = r_upd_idx;
   assign underflow   = r_underflow;
   assign stat_total  = r_total;
   assign stat_wrong  = r_wrong;

   // Entry storage needs no reset: only slots below count are ever read.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_idx_mem[r_tail] <= fetch_idx;
         r_loc_mem[r_tail] <= local_take;
         r_glb_mem[r_tail] <= global_take;
         r_fin_mem[r_tail] <= w_pred;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
         r_upd_en     <= 1'b0;
         r_upd_result <= 1'b0;
         r_upd_idx    <= '0;
         r_underflow  <= 1'b0;
         r_total      <= '0;
         r_wrong      <= '0;
         for (int i = 0; i < NumEnt; i++) begin
            r_chooser[i] <= 2'b01;
         end
      end else begin
         r_upd_en <= w_pop;
         if (w_pop) begin
            r_upd_idx    <= w_hd_idx;
            r_upd_result <= res_taken;
            r_total      <= r_total + 32'd1;
            if (w_hd_fin != res_taken) begin
               r_wrong <= r_wrong + 32'd1;
            end
            // Train the chooser only when the two predictors disagreed.
            if (w_hd_loc != w_hd_glb) begin
               if (w_hd_glb == res_taken) begin
                  if (r_chooser[w_hd_idx] != 2'b11) begin
                     r_chooser[w_hd_idx] <= r_chooser[w_hd_idx] + 2'd1;
                  end
               end else if (r_chooser[w_hd_idx] != 2'b00) begin
                  r_chooser[w_hd_idx] <= r_chooser[w_hd_idx] - 2'd1;
               end
            end
         end
         if (res_valid && (r_count == '0)) begin
            r_underflow <= 1'b1;
         end
         if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) begin
               r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
               r_head <= r_head + 1'b1;
            end
            if (w_push && !w_pop) begin
               r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
               r_count <= r_count - 1'b1;
            end
         end
      end
   end

endmodule
